// File: rtl/fft_cnn_sequencer_pkg.sv
// Shared definitions for the FFT -> 1-D CNN bearing-fault frame sequencer.
//   seq_state_t          : frame sequencer state encoding
//   CLS_W                : CNN class code width
//   SRC_ADDR_W           : signal-source address width
//   DEFAULT_NORMAL_CLASS : class code the CNN reports for a healthy bearing
//   is_wait_state()      : true in the states guarded by the timeout counter
package fft_cnn_pkg;

  localparam int unsigned CLS_W      = 4;
  localparam int unsigned SRC_ADDR_W = 19;

  localparam logic [CLS_W-1:0] DEFAULT_NORMAL_CLASS = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_FFT_WAIT = 3'd2,
    S_CLASSIFY = 3'd3,
    S_REPORT   = 3'd4,
    S_FLUSH    = 3'd5
  } seq_state_t;

  // States in which the sequencer waits on a downstream engine and may time out.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == S_FFT_WAIT) || (s == S_CLASSIFY);
  endfunction

endpackage

// File: rtl/fft_cnn_sequencer_if.sv
// Bus bundle between the frame sequencer and its surroundings
// (signal source, FFT core, CNN core, result consumer).
//   start                      : level, run frames continuously while high
//   src_ready / src_addr       : source sample available / current source address
//   fft_tvalid / fft_rst_n     : sample valid to FFT / FFT active-low reset
//   fft_done                   : FFT last-output pulse
//   cnn_rst_n / cnn_class      : CNN active-low reset-enable / CNN class (0 = none)
//   result_valid/result_class  : new-classification pulse / captured class
//   fault_count                : saturating count of non-normal results
//   busy / timeout_err         : sequencer not idle / sticky timeout flag
// master: the sequencer side. slave: the environment side.
interface fft_cnn_sequencer_if
  import fft_cnn_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) ();

  logic                  start;
  logic                  src_ready;
  logic [SRC_ADDR_W-1:0] src_addr;
  logic                  fft_tvalid;
  logic                  fft_rst_n;
  logic                  fft_done;
  logic                  cnn_rst_n;
  logic [CLS_W-1:0]      cnn_class;
  logic                  result_valid;
  logic [CLS_W-1:0]      result_class;
  logic [CNT_W-1:0]      fault_count;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  start, src_ready, src_addr, fft_done, cnn_class,
    output fft_tvalid, fft_rst_n, cnn_rst_n, result_valid, result_class,
           fault_count, busy, timeout_err
  );

  modport slave (
    output start, src_ready, src_addr, fft_done, cnn_class,
    input  fft_tvalid, fft_rst_n, cnn_rst_n, result_valid, result_class,
           fault_count, busy, timeout_err
  );

endinterface

// File: rtl/fft_cnn_sequencer_detect.sv
// cnn_result_detect: decides when the CNN output is a usable classification
// and captures it.
//   clk, reset  : clock, synchronous active-low reset
//   enable      : high while the sequencer is classifying
//   cnn_class   : raw CNN output, 0 = no result yet
//   detect      : combinational pulse, capture happens on this edge
//   capt_class  : last captured class, held until the next capture
// Build option SEQ_DEBOUNCE_EN: when defined, a class is accepted only after
// two consecutive nonzero cycles; otherwise the first nonzero cycle is taken.
module cnn_result_detect
  import fft_cnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CLS_W-1:0] cnn_class,
  output logic             detect,
  output logic [CLS_W-1:0] capt_class
);

  logic             nonzero_s;
  logic [CLS_W-1:0] capt_class_r;

  assign nonzero_s = enable && (cnn_class != {CLS_W{1'b0}});

`ifdef SEQ_DEBOUNCE_EN
  logic prev_nonzero_r;

  // Remember whether the previous enabled cycle carried a nonzero class;
  // cleared whenever classification is not running so frames never chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_nonzero_r <= 1'b0;
    end else begin
      prev_nonzero_r <= nonzero_s;
    end
  end

  assign detect = nonzero_s && prev_nonzero_r;
`else
  assign detect = nonzero_s;
`endif

  // Capture the class on the detect edge and hold it for the consumer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      capt_class_r <= {CLS_W{1'b0}};
    end else if (detect) begin
      capt_class_r <= cnn_class;
    end else begin
      capt_class_r <= capt_class_r;
    end
  end

  assign capt_class = capt_class_r;

endmodule

// File: rtl/fft_cnn_sequencer.sv
// fft_cnn_sequencer: frame-level controller for the FFT -> 1-D CNN pipeline.
// Streams FRAME_LEN source beats into the FFT, waits for FFT completion,
// enables the CNN, captures a stable classification, and keeps a saturating
// count of faulty results. FFT_WAIT and CLASSIFY are guarded by a timeout
// that aborts the frame through FLUSH and raises a sticky error flag.
//   clk   : clock
//   reset : synchronous, active-low; forces every output to its idle value
//   bus   : fft_cnn_sequencer_if.master (source, FFT, CNN and result signals)
// Build option SEQ_DEBOUNCE_EN selects two-cycle debounce of the CNN class
// (see cnn_result_detect); all outputs are registered.
module fft_cnn_sequencer
  import fft_cnn_pkg::*;
#(
  parameter int unsigned      FRAME_LEN    = 1024,
  parameter int unsigned      TIMEOUT      = 65535,
  parameter logic [CLS_W-1:0] NORMAL_CLASS = DEFAULT_NORMAL_CLASS,
  parameter int unsigned      ADDR_LIMIT   = 512000,
  parameter int unsigned      CNT_W        = 4
) (
  input logic                 clk,
  input logic                 reset,
  fft_cnn_sequencer_if.master bus
);

  localparam int unsigned BEAT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  // The counter holds cycles already spent in the state, so the cycle in
  // which it shows TIMEOUT-1 is the TIMEOUT-th and last one allowed.
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  seq_state_t        state_r;
  seq_state_t        state_next_s;
  logic [BEAT_W-1:0] beat_cnt_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [CNT_W-1:0]  fault_cnt_r;
  logic              fft_tvalid_r;
  logic              fft_rst_n_r;
  logic              cnn_rst_n_r;
  logic              result_valid_r;
  logic              busy_r;
  logic              timeout_err_r;

  logic              detect_s;
  logic [CLS_W-1:0]  capt_class_s;
  logic              beat_last_s;
  logic              tmo_hit_s;
  logic              tmo_abort_s;
  logic              addr_ok_s;
  logic              fault_inc_s;

  cnn_result_detect u_detect (
    .clk        (clk),
    .reset      (reset),
    .enable     (state_r == S_CLASSIFY),
    .cnn_class  (bus.cnn_class),
    .detect     (detect_s),
    .capt_class (capt_class_s)
  );

  assign beat_last_s = bus.src_ready && (beat_cnt_r == LAST_BEAT);
  assign tmo_hit_s   = is_wait_state(state_r) && (tmo_cnt_r == TMO_LAST);
  assign addr_ok_s   = (32'(bus.src_addr) <= ADDR_LIMIT);
  assign fault_inc_s = (state_r == S_REPORT) && (capt_class_s != NORMAL_CLASS) &&
                       addr_ok_s && (fault_cnt_r != CNT_MAX);

  // Next-state decode; a completion event beats a timeout in the same cycle.
  always_comb begin
    state_next_s = state_r;
    tmo_abort_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_next_s = S_FILL;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FILL: begin
        if (beat_last_s) begin
          state_next_s = S_FFT_WAIT;
        end else begin
          state_next_s = S_FILL;
        end
      end
      S_FFT_WAIT: begin
        if (bus.fft_done) begin
          state_next_s = S_CLASSIFY;
        end else if (tmo_hit_s) begin
          state_next_s = S_FLUSH;
          tmo_abort_s  = 1'b1;
        end else begin
          state_next_s = S_FFT_WAIT;
        end
      end
      S_CLASSIFY: begin
        if (detect_s) begin
          state_next_s = S_REPORT;
        end else if (tmo_hit_s) begin
          state_next_s = S_FLUSH;
          tmo_abort_s  = 1'b1;
        end else begin
          state_next_s = S_CLASSIFY;
        end
      end
      S_REPORT: begin
        state_next_s = S_FLUSH;
      end
      S_FLUSH: begin
        if (bus.start) begin
          state_next_s = S_FILL;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register plus control outputs decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= S_IDLE;
      fft_rst_n_r    <= 1'b0;
      cnn_rst_n_r    <= 1'b0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      fft_rst_n_r    <= (state_next_s == S_FILL) || (state_next_s == S_FFT_WAIT) ||
                        (state_next_s == S_CLASSIFY) || (state_next_s == S_REPORT);
      cnn_rst_n_r    <= (state_next_s == S_CLASSIFY) || (state_next_s == S_REPORT);
      result_valid_r <= (state_next_s == S_REPORT);
      busy_r         <= (state_next_s != S_IDLE);
    end
  end

  // Sample valid follows src_ready by one cycle while filling; the beat
  // counter is held at zero outside FILL so every frame starts clean.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fft_tvalid_r <= 1'b0;
      beat_cnt_r   <= {BEAT_W{1'b0}};
    end else if (state_r == S_FILL) begin
      fft_tvalid_r <= bus.src_ready;
      if (bus.src_ready) begin
        beat_cnt_r <= beat_cnt_r + 1'b1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end else begin
      fft_tvalid_r <= 1'b0;
      beat_cnt_r   <= {BEAT_W{1'b0}};
    end
  end

  // Timeout counter: restarts on every state change, runs only while waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_next_s != state_r) || !is_wait_state(state_r)) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timeout_err_r <= 1'b0;
    end else if (tmo_abort_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  // Saturating fault counter, updated on the edge that ends REPORT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_cnt_r <= {CNT_W{1'b0}};
    end else if (fault_inc_s) begin
      fault_cnt_r <= fault_cnt_r + 1'b1;
    end else begin
      fault_cnt_r <= fault_cnt_r;
    end
  end

  assign bus.fft_tvalid   = fft_tvalid_r;
  assign bus.fft_rst_n    = fft_rst_n_r;
  assign bus.cnn_rst_n    = cnn_rst_n_r;
  assign bus.result_valid = result_valid_r;
  assign bus.result_class = capt_class_s;
  assign bus.fault_count  = fault_cnt_r;
  assign bus.busy         = busy_r;
  assign bus.timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_fft_cnn_sequencer.sv
// Self-checking bench for fft_cnn_sequencer (FRAME_LEN=8, TIMEOUT=16).
// Stimulus tasks push expected results into a queue; a negedge monitor pops
// and compares whenever result_valid is seen, and checks the fault counter
// one cycle later.
module tb_fft_cnn_sequencer;
  import fft_cnn_pkg::*;

  typedef struct {
    logic [3:0] cls;
    logic [3:0] pre;
    logic [3:0] post;
  } exp_t;

`ifdef SEQ_DEBOUNCE_EN
  localparam logic [3:0] GLITCH_CLS = 4'd3;
  localparam logic [3:0] TIE_PRE    = 4'd3;
`else
  localparam logic [3:0] GLITCH_CLS = 4'd5;
  localparam logic [3:0] TIE_PRE    = 4'd0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   tvalid_beats;
  logic [3:0] model_fault;
  logic [3:0] cls_q[$];
  exp_t exp_q[$];
  logic       post_pending;
  logic [3:0] post_exp;

  fft_cnn_sequencer_if #(.CNT_W(4)) bus ();

  fft_cnn_sequencer #(
    .FRAME_LEN    (8),
    .TIMEOUT      (16),
    .NORMAL_CLASS (4'd7),
    .ADDR_LIMIT   (512000),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input seq_state_t s, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (dut.state_r != s && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(dut.state_r), 32'(s));
  endtask

  // Run one frame from FFT_WAIT on: pulse fft_done, replay cls_q as CNN output.
  task automatic do_frame(input logic [18:0] addr, input logic exp_res, input logic [3:0] exp_cls);
    exp_t e;
    bus.src_addr = addr;
    if (exp_res) begin
      e.cls = exp_cls;
      e.pre = model_fault;
      if (exp_cls != 4'd7 && addr <= 19'd512000 && model_fault != 4'd15)
        e.post = model_fault + 4'd1;
      else
        e.post = model_fault;
      model_fault = e.post;
      exp_q.push_back(e);
    end
    wait_state(S_FFT_WAIT, "reach_fft_wait");
    @(posedge clk); #1 bus.fft_done = 1'b1;
    @(posedge clk); #1 bus.fft_done = 1'b0;
    foreach (cls_q[i]) begin
      bus.cnn_class = cls_q[i];
      @(posedge clk); #1;
    end
    bus.cnn_class = 4'd0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fft_tvalid"},   32'(bus.fft_tvalid),   32'd0);
    check({tag, "_fft_rst_n"},    32'(bus.fft_rst_n),    32'd0);
    check({tag, "_cnn_rst_n"},    32'(bus.cnn_rst_n),    32'd0);
    check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_result_class"}, 32'(bus.result_class), 32'd0);
    check({tag, "_fault_count"},  32'(bus.fault_count),  32'd0);
    check({tag, "_busy"},         32'(bus.busy),         32'd0);
    check({tag, "_timeout_err"},  32'(bus.timeout_err),  32'd0);
    check({tag, "_state"},        32'(dut.state_r),      32'(S_IDLE));
  endtask

  // Beat counter for the first frame's fft_tvalid check.
  always @(negedge clk) begin
    if (bus.fft_tvalid === 1'b1) tvalid_beats++;
  end

  // Scoreboard monitor: pop on every result_valid, check fault_count a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (post_pending) begin
      check("fault_after_report", 32'(bus.fault_count), 32'(post_exp));
      post_pending = 1'b0;
    end
    if (bus.result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: result_valid=1 class %0d, none expected", bus.result_class);
      end else begin
        e = exp_q.pop_front();
        check("result_class", 32'(bus.result_class), 32'(e.cls));
        check("fault_during_report", 32'(bus.fault_count), 32'(e.pre));
        post_exp     = e.post;
        post_pending = 1'b1;
      end
    end
  end

  // Hard stop in case a wait outlives every bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    tvalid_beats  = 0;
    model_fault   = 4'd0;
    post_pending  = 1'b0;
    post_exp      = 4'd0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.src_ready = 1'b0;
    bus.src_addr  = 19'd0;
    bus.fft_done  = 1'b0;
    bus.cnn_class = 4'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    @(posedge clk); #1 reset = 1'b1;

    // First frame: 8 beats then FFT_WAIT with fft_tvalid low.
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.src_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("fill_beats", 32'(tvalid_beats), 32'd8);
    check("fill_tvalid_low", 32'(bus.fft_tvalid), 32'd0);
    check("fill_state", 32'(dut.state_r), 32'(S_FFT_WAIT));

    cls_q = '{4'd0, 4'd0, 4'd3, 4'd3};
    do_frame(19'd0, 1'b1, 4'd3);
    cls_q = '{4'd5, 4'd0, 4'd3, 4'd3};
    do_frame(19'd0, 1'b1, GLITCH_CLS);
    cls_q = '{4'd7, 4'd7, 4'd0, 4'd0};
    do_frame(19'd0, 1'b1, 4'd7);
    // 600000 does not fit a 19-bit address; use one just above the limit.
    cls_q = '{4'd3, 4'd3, 4'd0, 4'd0};
    do_frame(19'd520000, 1'b1, 4'd3);
    do_frame(19'd512000, 1'b1, 4'd3);

    // Detection lands in the last allowed CLASSIFY cycle: it must win.
    cls_q.delete();
    repeat (14) cls_q.push_back(4'd0);
    cls_q.push_back(TIE_PRE);
    cls_q.push_back(4'd3);
    do_frame(19'd0, 1'b1, 4'd3);

    // FFT never finishes: 16 cycles in FFT_WAIT, one FLUSH, next frame.
    wait_state(S_FFT_WAIT, "tmo_reach_fft_wait");
    repeat (15) @(negedge clk);
    check("tmo_last_wait_state", 32'(dut.state_r), 32'(S_FFT_WAIT));
    check("tmo_err_before", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    check("tmo_err_set", 32'(bus.timeout_err), 32'd1);
    check("tmo_flush_state", 32'(dut.state_r), 32'(S_FLUSH));
    check("tmo_flush_fft_rst_n", 32'(bus.fft_rst_n), 32'd0);
    check("tmo_flush_cnn_rst_n", 32'(bus.cnn_rst_n), 32'd0);
    @(negedge clk);
    check("tmo_next_fill", 32'(dut.state_r), 32'(S_FILL));
    check("tmo_next_fft_rst_n", 32'(bus.fft_rst_n), 32'd1);

    // CNN never answers: CLASSIFY times out without a result.
    cls_q.delete();
    repeat (16) cls_q.push_back(4'd0);
    do_frame(19'd0, 1'b0, 4'd0);
    check("ctmo_state", 32'(dut.state_r), 32'(S_FILL));

    // Saturation: 20 more fault frames.
    cls_q = '{4'd3, 4'd3, 4'd0, 4'd0};
    for (int k = 0; k < 20; k++) begin
      do_frame(19'd0, 1'b1, 4'd3);
    end
    check("sat_fault_count", 32'(bus.fault_count), 32'd15);
    check("sat_timeout_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset in the middle of CLASSIFY.
    wait_state(S_FFT_WAIT, "rst_reach_fft_wait");
    @(posedge clk); #1 bus.fft_done = 1'b1;
    @(posedge clk); #1 bus.fft_done = 1'b0;
    bus.cnn_class = 4'd3;
    reset         = 1'b0;
    bus.start     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("mid_classify_rst");
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.cnn_class = 4'd0;
    model_fault   = 4'd0;

    // start drops mid-FILL: the frame completes, then IDLE.
    @(posedge clk); #1 bus.start = 1'b1;
    wait_state(S_FILL, "drop_reach_fill");
    @(posedge clk);
    @(posedge clk); #1 bus.start = 1'b0;
    cls_q = '{4'd3, 4'd3, 4'd0, 4'd0};
    do_frame(19'd0, 1'b1, 4'd3);
    repeat (4) @(negedge clk);
    check("drop_state", 32'(dut.state_r), 32'(S_IDLE));
    check("drop_busy", 32'(bus.busy), 32'd0);
    check("drop_fft_rst_n", 32'(bus.fft_rst_n), 32'd0);
    check("drop_fault_count", 32'(bus.fault_count), 32'd1);
    check("drop_timeout_clear", 32'(bus.timeout_err), 32'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_cnn_sequencer.md
# fft_cnn_sequencer

Frame-level controller for the FFT → 1-D CNN bearing-fault pipeline. It streams FRAME_LEN samples from the signal source into the FFT, waits for FFT completion, and enables the CNN. It then captures a stable classification and maintains a saturating fault counter. It replaces ad-hoc reset/valid glue in the top level with one state machine that has timeout recovery.

## Interface
Parameters:
- FRAME_LEN, 1024, sample beats per FFT frame
- TIMEOUT, 65535, max cycles in FFT_WAIT or CLASSIFY before abort
- NORMAL_CLASS, 7, CNN class code meaning healthy bearing
- ADDR_LIMIT, 512000, faults counted only while src_addr ≤ this
- CNT_W, 4, fault counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  level; run frames continuously while high
- src_ready  in  1  source sample available this cycle
- src_addr  in  19  current source address
- fft_tvalid  out  1  sample valid to FFT
- fft_rst_n  out  1  FFT active-low reset
- fft_done  in  1  FFT last-output pulse
- cnn_rst_n  out  1  CNN active-low reset/enable
- cnn_class  in  4  CNN output; 0 = no result yet
- result_valid  out  1  one-cycle pulse, new classification
- result_class  out  4  captured class, held until next capture
- fault_count  out  CNT_W  saturating non-normal result count
- busy  out  1  state ≠ IDLE
- timeout_err  out  1  sticky, set on any timeout

## Operation
- States: IDLE, FILL, FFT_WAIT, CLASSIFY, REPORT, FLUSH.
- IDLE: fft_rst_n=0, cnn_rst_n=0. The FSM moves to FILL when start=1.
- FILL: fft_rst_n=1. fft_tvalid is registered from src_ready, and beat_cnt counts the asserted beats. After FRAME_LEN beats the FSM moves to FFT_WAIT, and fft_tvalid is 0 from then on.
- FFT_WAIT: fft_done moves the FSM to CLASSIFY. fft_done is ignored in every other state.
- CLASSIFY: cnn_rst_n=1. Detection fires when cnn_class≠0 on two consecutive cycles; the FSM then captures cnn_class and moves to REPORT.
- REPORT: one cycle. result_valid=1. fault_count increments if result_class≠NORMAL_CLASS, src_addr≤ADDR_LIMIT, and fault_count < 2^CNT_W−1.
- FLUSH: one cycle. cnn_rst_n=0, fft_rst_n=0, beat_cnt cleared. The FSM then goes to FILL if start=1, otherwise IDLE.
- Timeout: a counter is cleared on entry to FFT_WAIT or CLASSIFY. When it reaches TIMEOUT, the FSM sets timeout_err and goes to FLUSH; result_valid is not asserted.
- If detection and timeout occur in the same cycle, detection wins.
- If start falls mid-frame, the current frame completes, then the FSM goes to IDLE.
- Only reset clears timeout_err and fault_count.

## Timing
- Reset values: fft_tvalid=0, fft_rst_n=0, cnn_rst_n=0, result_valid=0, result_class=0, fault_count=0, busy=0, timeout_err=0, state=IDLE.
- fft_tvalid lags src_ready by 1 cycle.
- fft_done sampled at edge N: state=CLASSIFY and cnn_rst_n=1 from N+1.
- Second consecutive nonzero cnn_class sampled at edge M: result_valid=1 and result_class valid during M+1.
- fault_count updates at the edge ending REPORT.
- FLUSH → FILL costs 1 cycle. Frame overhead outside FILL is FFT latency + CNN latency + 3 cycles.
- reset=0 in any state forces all reset values on the next edge, including mid-FILL and mid-CLASSIFY.

## Configuration
- SEQ_DEBOUNCE_EN defined: capture requires two consecutive nonzero cnn_class cycles (as above).
- SEQ_DEBOUNCE_EN undefined: the first nonzero cycle captures, so result_valid falls 1 cycle earlier. All other behaviour is identical.

## Structure
- Shared package fft_cnn_pkg holds:
  - the state enum seq_state_t;
  - class width CLS_W=4;
  - the default NORMAL_CLASS;
  - the source address width 19.
- Sub-module cnn_result_detect: the debounce and capture logic, including the SEQ_DEBOUNCE_EN variant, with a detect pulse output. The timeout counter and FSM stay in the top.

## Test plan
- FRAME_LEN=8, src_ready constantly 1, start=1: exactly 8 fft_tvalid beats, then fft_tvalid=0 and state=FFT_WAIT.
- fft_done pulse, then cnn_class=0,0,3,3: one result_valid pulse with result_class=3 and fault_count 0→1.
- cnn_class=7,7 → result_valid, fault_count unchanged. cnn_class=3,3 with src_addr=600000 → fault_count unchanged.
- 20 fault frames with CNT_W=4 → fault_count saturates at 15 with no wrap.
- TIMEOUT=16, fft_done never asserted: timeout_err=1 after 16 cycles in FFT_WAIT, one FLUSH cycle with fft_rst_n=0, no result_valid, and the next frame starts.
- reset=0 asserted mid-CLASSIFY: all outputs at reset values on the next edge. start=0 mid-FILL: the frame completes, then IDLE and busy=0.
